mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the LC-3 datapath. Services CPU memory requests issued through MAR/MDR with MEM_EN/WE.
- Drives Data_to_CPU and the ready strobe R, which the MDR load path consumes.
- Routes addresses to external async SRAM (multi-cycle, wait-stated) or to the memory-mapped I/O word (switches in, hex display out).
- Sits between the CPU datapath and the board-level SRAM tristate/pin logic.

Parameters:
- WAIT_STATES, 2, SRAM access cycles per request (minimum 2).
- IO_ADDR, 16'hFFFF, CPU address decoded as the memory-mapped I/O word.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- MEM_EN  in  1  request valid; held high by CPU FSM until R seen
- WE  in  1  1 = write, 0 = read; sampled with MEM_EN
- MAR  in  16  request address
- MDR  in  16  write data
- Switches  in  16  board switch inputs (I/O read source)
- SRAM_DQ_in  in  16  SRAM data bus, read direction
- Data_to_CPU  out  16  read data, held until next read completes
- R  out  1  one-cycle ready pulse: request complete
- HEX_out  out  16  I/O write register, drives hex display
- SRAM_ADDR  out  20  {4'b0, latched address}
- SRAM_CE_N  out  1  chip enable, active-low
- SRAM_OE_N  out  1  output enable, active-low
- SRAM_WE_N  out  1  write enable, active-low
- SRAM_DQ_out  out  16  write data to pin tristate
- SRAM_DQ_oe  out  1  1 = top level drives SRAM_DQ with SRAM_DQ_out

Behaviour:
- Reset: state IDLE; Data_to_CPU=0, HEX_out=0, R=0, SRAM_ADDR=0, SRAM_DQ_out=0, CE_N=OE_N=WE_N=1, DQ_oe=0. Reset mid-access aborts at the next edge; strobes deassert that edge, and no R, HEX_out or Data_to_CPU update occurs.
- States: IDLE, ACCESS, DONE, HOLD.
- IDLE, cycle T, MEM_EN=1:
  - Latch MAR, MDR and WE at the edge ending T.
  - If MAR==IO_ADDR, go to DONE. On that edge a write loads HEX_out<=MDR, and a read loads Data_to_CPU<=Switches.
  - Otherwise go to ACCESS with count=0.
- ACCESS:
  - CE_N=0 and SRAM_ADDR is stable throughout.
  - Read: OE_N=0, DQ_oe=0. On the edge ending the last ACCESS cycle (count==WAIT_STATES-1), Data_to_CPU<=SRAM_DQ_in.
  - Write: DQ_oe=1 and SRAM_DQ_out=latched MDR throughout. WE_N=0 in all ACCESS cycles except the last, giving one cycle of data hold.
  - count increments each cycle; at WAIT_STATES-1, go to DONE.
- DONE: R=1 for exactly this cycle, with all SRAM strobes inactive. Next state is IDLE if MEM_EN=0, else HOLD.
- HOLD: R=0; wait until MEM_EN=0, then IDLE. This prevents a held MEM_EN from re-issuing the same request.
- Latency from MEM_EN sampled (cycle T) to R high: SRAM takes T+WAIT_STATES+1; I/O takes T+1.
- Strobe outputs are decoded from registered state only, with no combinational path from inputs.
- WE is ignored when MEM_EN=0. Requests arriving in ACCESS, DONE or HOLD are not accepted.
- Data_to_CPU changes only on read completion. Writes never disturb it.
- HEX_out changes only on an I/O write.

Decomposition:
- Shared package mem_pkg holds the state enum (IDLE, ACCESS, DONE, HOLD), the IO_ADDR default constant, and the SRAM address width (20).
- Natural single sub-module: sram_strobe_gen. It decodes state, count and the latched WE into CE_N/OE_N/WE_N/DQ_oe. The rest stays in mem_responder.

Test Plan:
- Reset for 2 cycles, then release -> all outputs at reset values; state IDLE; R stays 0 with MEM_EN=0 for 10 cycles.
- SRAM write: MAR=16'h0010, MDR=16'hBEEF, WE=1, MEM_EN held -> SRAM_ADDR=20'h00010; DQ_oe=1 for 2 cycles; WE_N low exactly 1 cycle; R high at T+3; Data_to_CPU unchanged.
- SRAM read: MAR=16'h0010, WE=0, model returns 16'hBEEF -> OE_N low 2 cycles; Data_to_CPU=16'hBEEF; R high at T+3, one cycle; HOLD until MEM_EN drops; no second access.
- I/O write then read: MAR=16'hFFFF, MDR=16'h1234, WE=1 -> HEX_out=16'h1234, R at T+1. Then Switches=16'h00A5, read -> Data_to_CPU=16'h00A5, R at T+1, SRAM CE_N stays 1.
- Reset asserted in the first ACCESS cycle of a write -> CE_N/WE_N return to 1 and DQ_oe to 0 at the next edge; R never pulses; a subsequent read returns the correct data.
- WAIT_STATES=4 build: back-to-back reads with MEM_EN dropped one cycle after R -> each R exactly 5 cycles after acceptance; no lost or duplicated requests.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory responder slice.
package mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // CPU address that selects the memory-mapped I/O word
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    // Width of the external SRAM address bus
    localparam int SRAM_ADDR_W = 20;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory request/response bus between the LC-3 datapath and the responder.
interface mem_responder_if;
    logic        MEM_EN;
    logic        WE;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Data_to_CPU;
    logic        R;

    // CPU datapath side
    modport master (
        output MEM_EN, WE, MAR, MDR,
        input  Data_to_CPU, R
    );

    // Memory responder side
    modport slave (
        input  MEM_EN, WE, MAR, MDR,
        output Data_to_CPU, R
    );
endinterface

// File: rtl/mem_responder_sram_strobe_gen.sv
// Decodes the responder's registered state into async SRAM control strobes.
// Inputs are all registers, so the strobes have no path from the CPU inputs.
module sram_strobe_gen
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int CW          = 1
) (
    input  state_t          state_i,
    input  logic [CW-1:0]   count_i,
    input  logic            we_i,
    output logic            ce_n_o,
    output logic            oe_n_o,
    output logic            we_n_o,
    output logic            dq_oe_o
);

    localparam logic [CW-1:0] LAST = CW'(WAIT_STATES - 1);

    // Strobes are active only while in ACCESS; WE_N releases one cycle early for data hold
    always_comb begin
        ce_n_o  = 1'b1;
        oe_n_o  = 1'b1;
        we_n_o  = 1'b1;
        dq_oe_o = 1'b0;
        if (state_i == ACCESS) begin
            ce_n_o = 1'b0;
            if (we_i) begin
                dq_oe_o = 1'b1;
                we_n_o  = (count_i == LAST);
            end else begin
                oe_n_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// LC-3 memory responder: services MAR/MDR requests from external async SRAM
// (wait-stated) or the memory-mapped I/O word (switches in, hex display out).
module mem_responder
    import mem_pkg::*;
#(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    mem_responder_if.slave         cpu,
    input  logic [15:0]            Switches,
    input  logic [15:0]            SRAM_DQ_in,
    output logic [15:0]            HEX_out,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic [15:0]            SRAM_DQ_out,
    output logic                   SRAM_DQ_oe
);

    localparam int              CW   = (WAIT_STATES > 2) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WAIT_STATES - 1);

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          we_q;
    logic [15:0]   rdata_q;
    logic [15:0]   hex_q;

    // Request FSM: accepts in IDLE, times SRAM wait states, pulses R in DONE, waits out MEM_EN in HOLD
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            hex_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu.MEM_EN) begin
                        addr_q  <= cpu.MAR;
                        wdata_q <= cpu.MDR;
                        we_q    <= cpu.WE;
                        count_q <= '0;
                        if (cpu.MAR == IO_ADDR) begin
                            // I/O word completes in a single cycle
                            state_q <= DONE;
                            if (cpu.WE) begin
                                hex_q <= cpu.MDR;
                            end else begin
                                rdata_q <= Switches;
                            end
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (count_q == LAST) begin
                        state_q <= DONE;
                        if (!we_q) begin
                            rdata_q <= SRAM_DQ_in;
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= cpu.MEM_EN ? HOLD : IDLE;
                end
                HOLD: begin
                    // A still-held MEM_EN belongs to the request just served
                    if (!cpu.MEM_EN) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sram_strobe_gen #(
        .WAIT_STATES (WAIT_STATES),
        .CW          (CW)
    ) u_strobe (
        .state_i (state_q),
        .count_i (count_q),
        .we_i    (we_q),
        .ce_n_o  (SRAM_CE_N),
        .oe_n_o  (SRAM_OE_N),
        .we_n_o  (SRAM_WE_N),
        .dq_oe_o (SRAM_DQ_oe)
    );

    assign cpu.R           = (state_q == DONE);
    assign cpu.Data_to_CPU = rdata_q;
    assign HEX_out         = hex_q;
    assign SRAM_ADDR       = {{(SRAM_ADDR_W - 16){1'b0}}, addr_q};
    assign SRAM_DQ_out     = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES 2 and 4) share one CPU
// stimulus stream; each has its own behavioural async SRAM.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic        we;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] switches;

    logic        r        [2];
    logic [15:0] data     [2];
    logic [15:0] hex      [2];
    logic [19:0] sram_addr[2];
    logic        ce_n     [2];
    logic        oe_n     [2];
    logic        we_n     [2];
    logic [15:0] dq_out   [2];
    logic        dq_oe    [2];
    logic [15:0] dq_in    [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: word store plus expected output registers
    logic [15:0] ref_mem [256];
    logic [15:0] ref_data;
    logic [15:0] ref_hex;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int WS = (gi == 0) ? 2 : 4;
        mem_responder_if bus ();
        logic [15:0] mem [256];

        assign bus.MEM_EN = mem_en;
        assign bus.WE     = we;
        assign bus.MAR    = mar;
        assign bus.MDR    = mdr;
        assign r[gi]      = bus.R;
        assign data[gi]   = bus.Data_to_CPU;
        assign dq_in[gi]  = (!ce_n[gi] && !oe_n[gi]) ? mem[sram_addr[gi][7:0]] : 16'hDEAD;

        mem_responder #(
            .WAIT_STATES (WS),
            .IO_ADDR     (16'hFFFF)
        ) u_dut (
            .Clk         (clk),
            .Reset       (reset),
            .cpu         (bus),
            .Switches    (switches),
            .SRAM_DQ_in  (dq_in[gi]),
            .HEX_out     (hex[gi]),
            .SRAM_ADDR   (sram_addr[gi]),
            .SRAM_CE_N   (ce_n[gi]),
            .SRAM_OE_N   (oe_n[gi]),
            .SRAM_WE_N   (we_n[gi]),
            .SRAM_DQ_out (dq_out[gi]),
            .SRAM_DQ_oe  (dq_oe[gi])
        );

        // SRAM contents start as a known address pattern
        initial begin
            for (int a = 0; a < 256; a++) mem[a] <= 16'(a) ^ 16'h5A5A;
        end

        // Write lands while chip and write enables are both low
        always @(posedge clk) begin
            if (!ce_n[gi] && !we_n[gi]) mem[sram_addr[gi][7:0]] <= dq_out[gi];
        end
    end

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", name, inst, act, exp);
        end
    endtask

    // Reference behaviour of one CPU request
    task model_step(input logic t_we, input logic [15:0] t_mar, input logic [15:0] t_mdr, input logic [15:0] t_sw);
        if (t_mar == 16'hFFFF) begin
            if (t_we) ref_hex = t_mdr;
            else      ref_data = t_sw;
        end else begin
            if (t_we) ref_mem[t_mar[7:0]] = t_mdr;
            else      ref_data = ref_mem[t_mar[7:0]];
        end
    endtask

    // One CPU request: hold MEM_EN until both DUTs respond, drop it `extra` cycles after, then watch briefly
    task automatic do_txn(input logic t_we, input logic [15:0] t_mar, input logic [15:0] t_mdr,
                          input logic [15:0] t_sw, input int extra,
                          input logic [15:0] exp_data, input logic [15:0] exp_hex);
        int lat[2], rcnt[2], ce[2], oe[2], wen[2], dqo[2], bad[2];
        logic [31:0] rd_data[2], rd_hex[2];
        int done_at, drop_k, ws;
        logic io;
        io = (t_mar == 16'hFFFF);
        for (int i = 0; i < 2; i++) begin
            lat[i] = -1; rcnt[i] = 0; ce[i] = 0; oe[i] = 0; wen[i] = 0; dqo[i] = 0; bad[i] = 0;
            rd_data[i] = 32'h1_0000; rd_hex[i] = 32'h1_0000;
        end
        done_at = -1;
        drop_k  = -1;
        mem_en = 1'b1; we = t_we; mar = t_mar; mdr = t_mdr; switches = t_sw;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!ce_n[i]) ce[i]++;
                if (!oe_n[i]) oe[i]++;
                if (!we_n[i]) wen[i]++;
                if (dq_oe[i]) dqo[i]++;
                if (!ce_n[i] && sram_addr[i] !== {4'h0, t_mar}) bad[i]++;
                if (dq_oe[i] && dq_out[i] !== t_mdr) bad[i]++;
                if (!we_n[i] && !dq_oe[i]) bad[i]++;
                if (!oe_n[i] && (dq_oe[i] || ce_n[i])) bad[i]++;
                if (r[i] && (!ce_n[i] || !oe_n[i] || !we_n[i] || dq_oe[i])) bad[i]++;
                if (r[i]) begin
                    rcnt[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = k;
                        rd_data[i] = 32'(data[i]);
                        rd_hex[i]  = 32'(hex[i]);
                    end
                end
            end
            if (done_at < 0 && rcnt[0] > 0 && rcnt[1] > 0) done_at = k;
            if (done_at >= 0 && drop_k < 0 && k == done_at + extra) begin
                mem_en = 1'b0;
                drop_k = k;
            end
            if (drop_k >= 0 && k == drop_k + 2) break;
        end
        if (drop_k < 0) begin
            mem_en = 1'b0;
            repeat (3) @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            ws = (i == 0) ? 2 : 4;
            check("latency",     i, 32'(lat[i]),  io ? 32'd1 : 32'(ws + 1));
            check("r_pulses",    i, 32'(rcnt[i]), 32'd1);
            check("ce_cycles",   i, 32'(ce[i]),   io ? 32'd0 : 32'(ws));
            check("oe_cycles",   i, 32'(oe[i]),   (io || t_we) ? 32'd0 : 32'(ws));
            check("we_cycles",   i, 32'(wen[i]),  (io || !t_we) ? 32'd0 : 32'(ws - 1));
            check("dqoe_cycles", i, 32'(dqo[i]),  (io || !t_we) ? 32'd0 : 32'(ws));
            check("bus_errors",  i, 32'(bad[i]),  32'd0);
            check("data_to_cpu", i, rd_data[i],   32'(exp_data));
            check("hex_out",     i, rd_hex[i],    32'(exp_hex));
        end
        $display("txn we=%0b mar=%h mdr=%h sw=%h extra=%0d lat=%0d/%0d data=%h/%h exp=%h hex=%h/%h exp=%h",
                 t_we, t_mar, t_mdr, t_sw, extra, lat[0], lat[1],
                 rd_data[0][15:0], rd_data[1][15:0], exp_data, rd_hex[0][15:0], rd_hex[1][15:0], exp_hex);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] mar;
        logic [15:0] mdr;
        logic [15:0] sw;
        int          extra;
        logic [15:0] exp_data;
        logic [15:0] exp_hex;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL global_timeout dut0: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rcount;
        // Directed table: expected values worked out by hand
        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h1234, 16'h0000, 0, 16'hBEEF, 16'h1234};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 0, 16'h00A5, 16'h1234};
        vecs[4] = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 2, 16'h5A4B, 16'h1234};
        vecs[5] = '{1'b1, 16'h0011, 16'hCAFE, 16'h0000, 0, 16'h5A4B, 16'h1234};
        vecs[6] = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1, 16'hCAFE, 16'h1234};

        for (int a = 0; a < 256; a++) ref_mem[a] = 16'(a) ^ 16'h5A5A;
        ref_data = 16'h0000;
        ref_hex  = 16'h0000;

        reset = 1'b1; mem_en = 1'b0; we = 1'b1; mar = 16'h0000; mdr = 16'h0000; switches = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_data",   i, 32'(data[i]),      32'h0);
            check("rst_hex",    i, 32'(hex[i]),       32'h0);
            check("rst_r",      i, 32'(r[i]),         32'h0);
            check("rst_addr",   i, 32'(sram_addr[i]), 32'h0);
            check("rst_dq_out", i, 32'(dq_out[i]),    32'h0);
            check("rst_ce_n",   i, 32'(ce_n[i]),      32'h1);
            check("rst_oe_n",   i, 32'(oe_n[i]),      32'h1);
            check("rst_we_n",   i, 32'(we_n[i]),      32'h1);
            check("rst_dq_oe",  i, 32'(dq_oe[i]),     32'h0);
        end
        rcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (r[0] || r[1]) rcount++;
        end
        check("idle_no_r", 0, 32'(rcount), 32'h0);

        for (int v = 0; v < 7; v++) begin
            model_step(vecs[v].we, vecs[v].mar, vecs[v].mdr, vecs[v].sw);
            do_txn(vecs[v].we, vecs[v].mar, vecs[v].mdr, vecs[v].sw, vecs[v].extra,
                   vecs[v].exp_data, vecs[v].exp_hex);
        end

        // Reset during the first ACCESS cycle of a write
        mem_en = 1'b1; we = 1'b1; mar = 16'h0030; mdr = 16'h1111;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("abort_in_access_ce", i, 32'(ce_n[i]), 32'h0);
            check("abort_in_access_we", i, 32'(we_n[i]), 32'h0);
        end
        reset = 1'b1;
        mem_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("abort_ce_n",  i, 32'(ce_n[i]),  32'h1);
            check("abort_we_n",  i, 32'(we_n[i]),  32'h1);
            check("abort_dq_oe", i, 32'(dq_oe[i]), 32'h0);
            check("abort_r",     i, 32'(r[i]),     32'h0);
            check("abort_data",  i, 32'(data[i]),  32'h0);
            check("abort_hex",   i, 32'(hex[i]),   32'h0);
        end
        reset = 1'b0;
        ref_data = 16'h0000;
        ref_hex  = 16'h0000;
        rcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (r[0] || r[1]) rcount++;
        end
        check("abort_no_r", 0, 32'(rcount), 32'h0);
        model_step(1'b0, 16'h0010, 16'h0000, 16'h0000);
        do_txn(1'b0, 16'h0010, 16'h0000, 16'h0000, 0, ref_data, ref_hex);

        // Back-to-back reads with MEM_EN dropped one cycle after R
        for (int n = 0; n < 3; n++) begin
            logic [15:0] a;
            a = (n == 1) ? 16'h0011 : 16'h0010;
            model_step(1'b0, a, 16'h0000, 16'h0000);
            do_txn(1'b0, a, 16'h0000, 16'h0000, 1, ref_data, ref_hex);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            logic        rw;
            logic [15:0] a, d, s;
            int          ex;
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(64, 255));
            d  = 16'($urandom);
            s  = 16'($urandom);
            ex = int'($urandom_range(0, 2));
            model_step(rw, a, d, s);
            do_txn(rw, a, d, s, ex, ref_data, ref_hex);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
